// File: rtl/ccd_adc_line_capture_if.sv
// Signal bundle between the CCD timing generator / AD9235 and the line capture block.
// The master side is the capture block; the slave side is the timing generator and readout.
interface ccd_adc_line_capture_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IDX_W  = 12
) ();
  logic              cdsclk1;
  logic              line_start;
  logic [1:0]        avg_mode;
  logic [DATA_W-1:0] adc_data;
  logic              adcclk;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;
  logic [IDX_W-1:0]  pixel_index;
  logic              line_done;
  logic              line_trunc;

  modport master (
    input  cdsclk1, line_start, avg_mode, adc_data,
    output adcclk, pixel_data, pixel_valid, pixel_index, line_done, line_trunc
  );

  modport slave (
    output cdsclk1, line_start, avg_mode, adc_data,
    input  adcclk, pixel_data, pixel_valid, pixel_index, line_done, line_trunc
  );
endinterface

// File: rtl/ccd_adc_line_capture.sv
// AD9235 line capture: ADC clock from cdsclk1, pipeline-latency flush, dummy-pixel skip,
// and optional 2/4/8 pixel binning over one CCD line.
module ccd_adc_line_capture #(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned PIPE_LAT     = 7,
  parameter int unsigned SKIP_PIX     = 32,
  parameter int unsigned PIX_PER_LINE = 3648,
  parameter int unsigned IDX_W        = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  ccd_adc_line_capture_if.master  bus
);

  localparam int unsigned ACC_W      = DATA_W + 3;
  localparam int unsigned FLUSH_LAST = PIPE_LAT + SKIP_PIX - 1;
  localparam int unsigned CONV_W     = $clog2(FLUSH_LAST + 2);
  localparam int unsigned SAMP_W     = $clog2(PIX_PER_LINE);

  typedef enum logic [1:0] {IDLE, FLUSH, ACTIVE, DONE} state_t;

  state_t              state, state_d;
  logic                s1, s2, edge_r, edge_d;
  logic [CONV_W-1:0]   conv, conv_d;
  logic [SAMP_W-1:0]   samp, samp_d;
  logic [ACC_W-1:0]    acc, acc_d, sum;
  logic [1:0]          mode, mode_d;
  logic [2:0]          bin_mask;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                trunc_q, trunc_d;

  // State register plus all datapath/output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s1      <= 1'b0;
      s2      <= 1'b0;
      edge_r  <= 1'b0;
      conv    <= '0;
      samp    <= '0;
      acc     <= '0;
      mode    <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state   <= state_d;
      s1      <= bus.cdsclk1;
      s2      <= s1;
      edge_r  <= edge_d;
      conv    <= conv_d;
      samp    <= samp_d;
      acc     <= acc_d;
      mode    <= mode_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
    end
  end

  // Next-state, counters and binning; a line_start overrides whatever the state would do
  always_comb begin
    state_d  = state;
    edge_d   = s1 & ~s2;
    conv_d   = conv;
    samp_d   = samp;
    acc_d    = acc;
    mode_d   = mode;
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    trunc_d  = 1'b0;
    sum      = acc + ACC_W'(bus.adc_data);
    bin_mask = 3'((4'd1 << mode) - 4'd1);

    if (bus.line_start) begin
      trunc_d = (state == FLUSH) || (state == ACTIVE);
      state_d = FLUSH;
      mode_d  = bus.avg_mode;
      conv_d  = '0;
      samp_d  = '0;
      acc_d   = '0;
      // A coincident edge is conversion 0 of the new line
      if (edge_r) begin
        conv_d = CONV_W'(1);
        if (FLUSH_LAST == 0) state_d = ACTIVE;
      end
    end else begin
      unique case (state)
        IDLE: ;
        FLUSH: begin
          if (edge_r) begin
            conv_d = conv + CONV_W'(1);
            if (conv == CONV_W'(FLUSH_LAST)) state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (edge_r) begin
            acc_d  = sum;
            samp_d = samp + SAMP_W'(1);
            // Bins are aligned to the line start, so the low sample bits mark bin completion
            if ((samp[2:0] & bin_mask) == bin_mask) begin
              valid_d = 1'b1;
              data_d  = DATA_W'(sum >> mode);
              idx_d   = IDX_W'(samp >> mode);
              acc_d   = '0;
              if (samp == SAMP_W'(PIX_PER_LINE - 1)) begin
                done_d  = 1'b1;
                samp_d  = '0;
                state_d = DONE;
              end
            end
          end
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  assign bus.adcclk      = s1;
  assign bus.pixel_data  = data_q;
  assign bus.pixel_index = idx_q;
  assign bus.pixel_valid = valid_q;
  assign bus.line_done   = done_q;
  assign bus.line_trunc  = trunc_q;

endmodule

// File: tb/tb_ccd_adc_line_capture.sv
// Directed bench for ccd_adc_line_capture: edge-numbered line model plus literal checks.
module tb_ccd_adc_line_capture;

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned PIPE_LAT = 7;
  localparam int unsigned SKIP_PIX = 2;
  localparam int unsigned PIX      = 16;
  localparam int unsigned IDX_W    = 12;
  localparam int          FIRST    = PIPE_LAT + SKIP_PIX;

  typedef struct {
    int cyc;
    int data;
    int idx;
    bit done;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic cds_d;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  out_t exp_q[$];
  out_t obs_q[$];
  out_t cur;
  out_t ob;
  int   samples[$];
  int   edge_rc[$];
  int   last_data = 0;
  int   last_idx = 0;
  int   exp_trunc_cyc = -1;
  int   trunc_seen = 0;
  bit   line_open = 1'b0;
  int   e_num = 0;
  int   m_mode = 0;
  bit   ev;

  ccd_adc_line_capture_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  ccd_adc_line_capture #(
    .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT), .SKIP_PIX(SKIP_PIX),
    .PIX_PER_LINE(PIX), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adcclk is cdsclk1 delayed by one clock, cleared by reset
  always @(posedge clk or posedge rst)
    if (rst) cds_d <= 1'b0;
    else     cds_d <= bus.cdsclk1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line restart seen by the model; trunc expected if the previous line was still open
  task automatic model_ls(input int trunc_cyc, input int mode);
    if (line_open) exp_trunc_cyc = trunc_cyc;
    line_open = 1'b1;
    m_mode    = mode;
    e_num     = 0;
    samples.delete();
  endtask

  // Edge e of the line: edges FIRST..FIRST+PIX-1 are active samples, grouped in bins
  task automatic model_edge(input int rc, input int val);
    int   bin;
    int   sum;
    out_t o;
    if (line_open && e_num >= FIRST && e_num < FIRST + int'(PIX)) begin
      bin = 1 << m_mode;
      samples.push_back(val);
      if (samples.size() == bin) begin
        sum = 0;
        foreach (samples[j]) sum += samples[j];
        o.cyc  = rc + 3;
        o.data = sum / bin;
        o.idx  = (e_num - FIRST) / bin;
        o.done = (e_num == FIRST + int'(PIX) - 1);
        exp_q.push_back(o);
        samples.delete();
      end
      if (e_num == FIRST + int'(PIX) - 1) line_open = 1'b0;
    end
    e_num++;
  endtask

  task automatic model_reset();
    line_open = 1'b0;
    exp_q.delete();
    samples.delete();
    last_data     = 0;
    last_idx      = 0;
    exp_trunc_cyc = -1;
  endtask

  task automatic pulse_ls(input int mode);
    bus.line_start = 1'b1;
    bus.avg_mode   = 2'(mode);
    model_ls(cyc + 1, mode);
    tick();
    bus.line_start = 1'b0;
    bus.avg_mode   = ~2'(mode);
  endtask

  // One cdsclk1 period of 6 clocks; optional line_start coincident with the edge cycle
  task automatic strobe(input int val, input bit ls, input int lsmode);
    int rc;
    rc = cyc;
    edge_rc.push_back(rc);
    bus.cdsclk1  = 1'b1;
    bus.adc_data = DATA_W'(val);
    tick();
    tick();
    if (ls) begin
      bus.line_start = 1'b1;
      bus.avg_mode   = 2'(lsmode);
    end
    tick();
    bus.line_start = 1'b0;
    bus.avg_mode   = ~2'(lsmode);
    bus.cdsclk1    = 1'b0;
    if (ls) begin
      model_ls(rc + 3, lsmode);
      e_num = 1;
    end else begin
      model_edge(rc, val);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic run_line(input int mode, input int n, input bit cval_en, input int cval,
                          input int trunc_at);
    int v;
    obs_q.delete();
    edge_rc.delete();
    trunc_seen = 0;
    pulse_ls(mode);
    tick();
    for (int i = 0; i < n; i++) begin
      if (cval_en)                        v = cval;
      else if (trunc_at >= 0 && i >= trunc_at) v = i - trunc_at;
      else                                v = i;
      strobe(v, (i == trunc_at), mode);
    end
    repeat (4) tick();
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    cur.done = 1'b0;
    if (ev) begin
      cur       = exp_q.pop_front();
      last_data = cur.data;
      last_idx  = cur.idx;
    end
    chk("pixel_valid", int'(bus.pixel_valid), int'(ev));
    chk("pixel_data", int'(bus.pixel_data), last_data);
    chk("pixel_index", int'(bus.pixel_index), last_idx);
    chk("line_done", int'(bus.line_done), int'(ev && cur.done));
    chk("line_trunc", int'(bus.line_trunc), int'(cyc == exp_trunc_cyc));
    chk("adcclk", int'(bus.adcclk), int'(cds_d));
    if (bus.pixel_valid) begin
      ob.cyc  = cyc;
      ob.data = int'(bus.pixel_data);
      ob.idx  = int'(bus.pixel_index);
      ob.done = bus.line_done;
      obs_q.push_back(ob);
    end
    if (bus.line_trunc) trunc_seen++;
  end

  initial begin
    rst            = 1'b0;
    bus.cdsclk1    = 1'b0;
    bus.line_start = 1'b0;
    bus.avg_mode   = 2'd0;
    bus.adc_data   = '0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_pixel_valid", int'(bus.pixel_valid), 0);
    chk("rst_adcclk", int'(bus.adcclk), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Mode 0: 30 edges, outputs at edges 9..24
    run_line(0, 30, 1'b0, 0, -1);
    chk("t1_count", obs_q.size(), 16);
    if (obs_q.size() == 16) begin
      chk("t1_first_data", obs_q[0].data, 9);
      chk("t1_first_idx", obs_q[0].idx, 0);
      chk("t1_latency", obs_q[0].cyc - edge_rc[9], 3);
      chk("t1_last_data", obs_q[15].data, 24);
      chk("t1_last_idx", obs_q[15].idx, 15);
      chk("t1_last_done", int'(obs_q[15].done), 1);
    end

    // Mode 2: bins of four
    run_line(2, 30, 1'b0, 0, -1);
    chk("t2_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("t2_d0", obs_q[0].data, 10);
      chk("t2_d1", obs_q[1].data, 14);
      chk("t2_d2", obs_q[2].data, 18);
      chk("t2_d3", obs_q[3].data, 22);
      chk("t2_idx3", obs_q[3].idx, 3);
      chk("t2_done", int'(obs_q[3].done), 1);
    end

    // Mode 3 at full scale
    run_line(3, 30, 1'b1, 'hFFF, -1);
    chk("t3_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t3_d0", obs_q[0].data, 'hFFF);
      chk("t3_d1", obs_q[1].data, 'hFFF);
      chk("t3_idx1", obs_q[1].idx, 1);
    end

    // Restart coincident with edge 14, mid-ACTIVE
    run_line(0, 42, 1'b0, 0, 14);
    chk("t4_trunc_count", trunc_seen, 1);
    chk("t4_count", obs_q.size(), 21);
    if (obs_q.size() == 21) begin
      chk("t4_no_early_done", int'(obs_q[4].done), 0);
      chk("t4_restart_data", obs_q[5].data, 9);
      chk("t4_restart_idx", obs_q[5].idx, 0);
      chk("t4_restart_lat", obs_q[5].cyc - edge_rc[14], 57);
      chk("t4_last_done", int'(obs_q[20].done), 1);
    end

    // Reset mid-ACTIVE with adcclk high
    run_line(0, 12, 1'b0, 0, -1);
    chk("t5_pre_count", obs_q.size(), 3);
    bus.cdsclk1  = 1'b1;
    bus.adc_data = '0;
    tick();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_pixel_data", int'(bus.pixel_data), 0);
    chk("t5_pixel_index", int'(bus.pixel_index), 0);
    chk("t5_pixel_valid", int'(bus.pixel_valid), 0);
    chk("t5_line_done", int'(bus.line_done), 0);
    chk("t5_line_trunc", int'(bus.line_trunc), 0);
    chk("t5_adcclk", int'(bus.adcclk), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.cdsclk1 = 1'b0;
    repeat (3) tick();
    obs_q.delete();
    for (int i = 0; i < 12; i++) strobe(i, 1'b0, 0);
    repeat (4) tick();
    chk("t5_no_valid", obs_q.size(), 0);

    // cdsclk1 stuck high while idle
    obs_q.delete();
    bus.cdsclk1 = 1'b1;
    tick();
    chk("t6_adcclk_high", int'(bus.adcclk), 1);
    repeat (99) tick();
    chk("t6_no_valid", obs_q.size(), 0);
    bus.cdsclk1 = 1'b0;
    repeat (3) tick();
    run_line(0, 30, 1'b0, 0, -1);
    chk("t6_recover_count", obs_q.size(), 16);
    if (obs_q.size() == 16) chk("t6_recover_data", obs_q[0].data, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccd_adc_line_capture.md
# ccd_adc_line_capture

Parametrised successor to the single-sample AD9235 capture path. It generates the ADC clock from the CCD timing strobe and compensates the ADC pipeline latency. It frames one CCD line of pixels, discards dummy/dark pixels and optionally bins 2/4/8 adjacent pixels. It sits between the CCD timing generator and the line buffer/readout logic, entirely in the 100 MHz `clk` domain.

## Interface
Parameters:
- `DATA_W`, 12: ADC data width.
- `PIPE_LAT`, 7: ADC pipeline latency, in ADC conversions.
- `SKIP_PIX`, 32: dummy pixels discarded at the start of each line.
- `PIX_PER_LINE`, 3648: active pixels per line; must be a multiple of 8.
- `IDX_W`, 12: width of `pixel_index`; must satisfy 2^IDX_W ≥ PIX_PER_LINE.

Ports:
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset, asynchronous, active-high.
- `cdsclk1` input 1: CCD sample strobe, synchronous to `clk`; high and low phases each ≥2 `clk` cycles.
- `line_start` input 1: one-cycle pulse from the timing generator at the start of each line.
- `avg_mode` input 2: binning factor 2^avg_mode (0 = off, 1 = 2, 2 = 4, 3 = 8); sampled only on `line_start`.
- `adc_data` input DATA_W: AD9235 parallel output.
- `adcclk` output 1: ADC clock, `cdsclk1` registered once.
- `pixel_data` output DATA_W: binned pixel value.
- `pixel_valid` output 1: one-cycle strobe qualifying `pixel_data` and `pixel_index`.
- `pixel_index` output IDX_W: output pixel number within the line, starting at 0.
- `line_done` output 1: one-cycle pulse, coincident with the last `pixel_valid` of the line.
- `line_trunc` output 1: one-cycle pulse when `line_start` arrives in FLUSH or ACTIVE.

## Operation
- Edge detect:
  - s1 <= `cdsclk1`; s2 <= s1; `adcclk` = s1.
  - edge = s1 & ~s2. One edge = one ADC conversion.
- Conversion counter `conv` resets to 0 on `line_start` and increments on each edge.
  - Data present on `adc_data` at edge number e belongs to conversion e−PIPE_LAT.
  - `adc_data` is registered in the edge cycle.
- States:
  - IDLE: reset state; edges are ignored. `line_start` → FLUSH; latch `avg_mode`; clear `conv`, the accumulator and the output index.
  - FLUSH: count edges. The edge with `conv` == PIPE_LAT+SKIP_PIX−1 → ACTIVE.
  - ACTIVE: each edge adds the sample to the accumulator (DATA_W+3 bits) and increments the bin counter.
    - When the bin counter reaches 2^mode: `pixel_data` = acc >> mode (truncating), pulse `pixel_valid`, increment `pixel_index`, clear the accumulator.
    - After PIX_PER_LINE samples have been accumulated → DONE, with `line_done` pulsed alongside the final `pixel_valid`.
  - DONE: edges are ignored. `line_start` → FLUSH. Next cycle → IDLE.
- Each line produces exactly PIX_PER_LINE >> mode output pixels.
- Binning arithmetic cannot overflow: the 8× sum of full-scale samples fits in DATA_W+3 bits, and the output is always ≤ 2^DATA_W−1.
- `line_start` in FLUSH or ACTIVE:
  - Pulse `line_trunc`. The partial bin is discarded, with no `pixel_valid` and no `line_done`.
  - Restart at FLUSH with the newly sampled `avg_mode`.
- `line_start` and an edge in the same cycle: the restart wins, and that edge counts as conversion 0 of the new line.
- Changes on `avg_mode` outside `line_start` have no effect.

## Timing
- Reset values:
  - `adcclk` = 0, `pixel_data` = 0, `pixel_valid` = 0, `pixel_index` = 0, `line_done` = 0, `line_trunc` = 0.
  - State = IDLE; s1 = s2 = 0.
- `adcclk` lags `cdsclk1` by 1 `clk` cycle.
- Edge cycle = 2 `clk` cycles after the `cdsclk1` rise.
- `pixel_valid` asserts 1 cycle after the edge cycle that completes a bin. Total latency is 3 `clk` cycles from the `cdsclk1` rise.
- `pixel_data` and `pixel_index` hold their values until the next `pixel_valid`.
- `line_trunc` asserts 1 cycle after the offending `line_start`.
- Minimum `cdsclk1` period is 4 `clk` cycles; the block is unspecified for faster strobes.

## Test plan
Bench parameters: PIX_PER_LINE=16, SKIP_PIX=2, PIPE_LAT=7. The bench drives `adc_data` = edge number e.

1. Mode 0:
   - Stimulus: `line_start`, then 30 edges.
   - Required: first `pixel_valid` at edge 9 with data 9, index 0. 16 outputs, data 9..24. `line_done` with index 15, data 24. Edges 25..29 produce nothing.
2. Mode 2:
   - Stimulus: same line.
   - Required: 4 outputs with data 10, 14, 18, 22 (e.g. (9+10+11+12)>>2 = 10), indices 0..3. `line_done` on index 3.
3. Mode 3 with `adc_data` = 0xFFF constant:
   - Required: 2 outputs, each 0xFFF; no overflow.
4. Truncation:
   - Stimulus: `line_start` again at edge 14, mid-ACTIVE.
   - Required: `line_trunc` pulse; no `line_done`. The next first output comes at the 9th edge after the restart.
5. Reset:
   - Stimulus: assert `rst` mid-ACTIVE.
   - Required: all outputs read 0 immediately. After release, edges without `line_start` produce no `pixel_valid`.
6. Stuck strobe:
   - Stimulus: `cdsclk1` held high for 100 cycles.
   - Required: `adcclk` = 1 after 1 cycle. No conversion counted and no output.
